// File: rtl/sky130_as_sc_hs__cell_selftest.sv
`default_nettype none
// ============================================================================
// Module      : sky130_as_sc_hs__cell_selftest
// Description : On-chip functional checker for the logic cells inv_2, buff_2,
//               nand2_2, nand2b_2, and2_2, nor2_2, nor2b_2, or2_2 and
//               dfxtp_1. Every 2-input vector is swept PASSES times. Each
//               cell output is compared with its golden function. Results
//               are a sticky per-cell failure mask and a saturating count of
//               compare edges that had at least one mismatch.
// Ports       : CLK, RESET_B (sync, active low), START, FORCE_ERR (inverts
//               the nand2 golden value for the checker's own self-test),
//               BUSY, DONE, PASS, ERR_CNT[ERR_W], FAIL_MASK[9]
//               (0 inv, 1 buff, 2 nand2, 3 nand2b, 4 and2, 5 nor2, 6 nor2b,
//               7 or2, 8 dfxtp), VPWR/VGND/VPB/VNB (supply, no logic role)
// Revision    : 1.0  initial release
// ============================================================================
module sky130_as_sc_hs__cell_selftest #(
    parameter int PASSES = 4,
    parameter int ERR_W  = 8
) (
    input  logic             CLK,
    input  logic             RESET_B,
    input  logic             START,
    input  logic             FORCE_ERR,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [8:0]       FAIL_MASK,
    input  logic             VPWR,
    input  logic             VGND,
    input  logic             VPB,
    input  logic             VNB
);

    localparam int                 c_N_EDGES = 4 * PASSES;
    localparam int                 c_IDX_W   = $clog2(c_N_EDGES + 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_N_EDGES);
    localparam logic [ERR_W-1:0]   c_ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_a;
    logic                 r_b;
    logic                 r_prev_a;
    logic                 r_force;
    logic [c_IDX_W-1:0]   r_idx;
    logic [ERR_W-1:0]     r_err_cnt;
    logic [8:0]           r_fail_mask;

    // Supplies carry no logic; reduced here only so they are consumed.
    logic w_unused_supply;
    assign w_unused_supply = ^{VPWR, VGND, VPB, VNB};

    // ------------------------------------------------------------------
    // Cells under test
    // ------------------------------------------------------------------
    logic w_y_inv, w_y_buf, w_y_nand2, w_y_nand2b;
    logic w_y_and2, w_y_nor2, w_y_nor2b, w_y_or2;
    logic r_dff_q;

    assign w_y_inv    = ~r_a;
    assign w_y_buf    = r_a;
    assign w_y_nand2  = ~(r_a & r_b);
    assign w_y_nand2b = ~(~r_a & r_b);
    assign w_y_and2   = r_a & r_b;
    assign w_y_nor2   = ~(r_a | r_b);
    assign w_y_nor2b  = ~(~r_a | r_b);
    assign w_y_or2    = r_a | r_b;

    // Flop under test: free-running and without reset, like the real cell.
    always_ff @(posedge CLK) begin
        r_dff_q <= r_a;
    end

    // ------------------------------------------------------------------
    // Golden model and compare
    // ------------------------------------------------------------------
    logic [8:0] w_y;
    logic [8:0] w_gold;
    logic [8:0] w_mis;
    logic       w_dff_chk;

    assign w_y = {r_dff_q, w_y_or2, w_y_nor2b, w_y_nor2, w_y_and2,
                  w_y_nand2b, w_y_nand2, w_y_buf, w_y_inv};

    assign w_gold = {r_prev_a,
                     r_a | r_b,
                     r_a & ~r_b,
                     ~(r_a | r_b),
                     r_a & r_b,
                     r_a | ~r_b,
                     ~(r_a & r_b) ^ r_force,
                     r_a,
                     ~r_a};

    // The flop output is only defined once it has captured a stimulus
    // value of this run, i.e. from the second compare edge on.
    assign w_dff_chk = (r_idx >= c_IDX_W'(2));

    // Case inequality so an X on a cell output counts as a mismatch.
    always_comb begin
        w_mis = '0;
        for (int k = 0; k < 8; k++) begin
            w_mis[k] = (w_y[k] !== w_gold[k]);
        end
        w_mis[8] = w_dff_chk && (w_y[8] !== w_gold[8]);
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (START) w_state_nxt = S_RUN;
            S_RUN:   if (r_idx == c_IDX_LAST) w_state_nxt = S_DONE;
            S_DONE:  if (START) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_B) begin
            r_state     <= S_IDLE;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_prev_a    <= 1'b0;
            r_force     <= 1'b0;
            r_idx       <= '0;
            r_err_cnt   <= '0;
            r_fail_mask <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        r_err_cnt   <= '0;
                        r_fail_mask <= '0;
                        r_force     <= FORCE_ERR;
                        r_idx       <= c_IDX_W'(1);
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_prev_a <= r_a;
                    if (|w_mis) begin
                        r_fail_mask <= r_fail_mask | w_mis;
                        if (r_err_cnt != c_ERR_MAX) begin
                            r_err_cnt <= r_err_cnt + ERR_W'(1);
                        end
                    end
                    // r_idx holds the number of the vector to load next.
                    if (r_idx != c_IDX_LAST) begin
                        r_a   <= r_idx[1];
                        r_b   <= r_idx[0];
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY      = (r_state == S_RUN);
    assign DONE      = (r_state == S_DONE);
    assign PASS      = (r_state == S_DONE) && (r_err_cnt == '0);
    assign ERR_CNT   = r_err_cnt;
    assign FAIL_MASK = r_fail_mask;

endmodule
`default_nettype wire

// File: tb/tb_sky130_as_sc_hs__cell_selftest.sv
`default_nettype none
// ============================================================================
// Module      : tb_sky130_as_sc_hs__cell_selftest
// Description : Directed self-checking bench for the cell self-test block.
//               A second instance with ERR_W=3 shares all inputs and is used
//               for the saturation scenario.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sky130_as_sc_hs__cell_selftest;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       start;
    logic       force_err;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic [8:0] fail_mask;
    logic       busy3, done3, pass3;
    logic [2:0] err_cnt3;
    logic [8:0] fail_mask3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sky130_as_sc_hs__cell_selftest #(.PASSES(4), .ERR_W(8)) dut (
        .CLK(clk), .RESET_B(rst_b), .START(start), .FORCE_ERR(force_err),
        .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt),
        .FAIL_MASK(fail_mask),
        .VPWR(1'b1), .VGND(1'b0), .VPB(1'b1), .VNB(1'b0)
    );

    sky130_as_sc_hs__cell_selftest #(.PASSES(4), .ERR_W(3)) dut3 (
        .CLK(clk), .RESET_B(rst_b), .START(start), .FORCE_ERR(force_err),
        .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_CNT(err_cnt3),
        .FAIL_MASK(fail_mask3),
        .VPWR(1'b1), .VGND(1'b0), .VPB(1'b1), .VNB(1'b0)
    );

    // Advance one active edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; start = 1'b0; force_err = 1'b0;
        tick(); tick();
        total++;
        if ({busy, done, pass} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, pass});
        end
        total++;
        if ({err_cnt, fail_mask} !== 17'h0) begin
            bad++; $display("FAIL reset_results: got cnt=%0d mask=%h want 0/000", err_cnt, fail_mask);
        end
        rst_b = 1'b1;
        tick();
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++; $display("FAIL idle_hold: got busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_clean_run();
        start = 1'b1; force_err = 1'b0;
        tick();
        start = 1'b0;
        total++;
        if ({busy, done, pass} !== 3'b100) begin
            bad++; $display("FAIL clean_accept: got %b want 100", {busy, done, pass});
        end
        for (int k = 1; k <= 15; k++) tick();
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++; $display("FAIL clean_e15: got busy/done=%b want 10", {busy, done});
        end
        tick();
        total++;
        if ({busy, done, pass} !== 3'b011) begin
            bad++; $display("FAIL clean_e16_flags: got %b want 011", {busy, done, pass});
        end
        total++;
        if (err_cnt !== 8'd0 || fail_mask !== 9'h000) begin
            bad++; $display("FAIL clean_results: got cnt=%0d mask=%h want 0/000", err_cnt, fail_mask);
        end
        tick();
        total++;
        if ({busy, done, pass} !== 3'b011) begin
            bad++; $display("FAIL clean_done_hold: got %b want 011", {busy, done, pass});
        end
    endtask

    task automatic test_force_err();
        start = 1'b1; force_err = 1'b1;
        tick();
        start = 1'b0; force_err = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 5) begin
                total++;
                if (err_cnt !== 8'd5 || fail_mask !== 9'h004) begin
                    bad++; $display("FAIL force_live_e5: got cnt=%0d mask=%h want 5/004", err_cnt, fail_mask);
                end
            end
            if (k == 7) begin
                total++;
                if (err_cnt3 !== 3'd7) begin
                    bad++; $display("FAIL sat_e7: got %0d want 7", err_cnt3);
                end
            end
        end
        total++;
        if ({busy, done, pass} !== 3'b010) begin
            bad++; $display("FAIL force_flags: got %b want 010", {busy, done, pass});
        end
        total++;
        if (err_cnt !== 8'd16 || fail_mask !== 9'h004) begin
            bad++; $display("FAIL force_results: got cnt=%0d mask=%h want 16/004", err_cnt, fail_mask);
        end
        total++;
        if (err_cnt3 !== 3'd7 || fail_mask3 !== 9'h004 || pass3 !== 1'b0) begin
            bad++; $display("FAIL sat_final: got cnt=%0d mask=%h pass=%b want 7/004/0", err_cnt3, fail_mask3, pass3);
        end
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (err_cnt !== 8'd0 || fail_mask !== 9'h000 || busy !== 1'b1) begin
            bad++; $display("FAIL restart_clear: got cnt=%0d mask=%h busy=%b want 0/000/1", err_cnt, fail_mask, busy);
        end
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) start = 1'b1;
            tick();
            start = 1'b0;
            if (k == 5) begin
                total++;
                if ({busy, done, err_cnt} !== {2'b10, 8'd0}) begin
                    bad++; $display("FAIL ignore_e5: got busy/done=%b cnt=%0d want 10/0", {busy, done}, err_cnt);
                end
            end
            if (k == 15) begin
                total++;
                if ({busy, done} !== 2'b10) begin
                    bad++; $display("FAIL ignore_e15: got busy/done=%b want 10", {busy, done});
                end
            end
        end
        total++;
        if ({busy, done, pass, err_cnt} !== {3'b011, 8'd0}) begin
            bad++; $display("FAIL ignore_e16: got flags=%b cnt=%0d want 011/0", {busy, done, pass}, err_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; force_err = 1'b1;
        tick();
        start = 1'b0; force_err = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        total++;
        if (err_cnt !== 8'd6) begin
            bad++; $display("FAIL midrun_e6: got %0d want 6", err_cnt);
        end
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        total++;
        if ({busy, done, pass, err_cnt, fail_mask} !== 20'h0) begin
            bad++; $display("FAIL midrun_reset: got flags=%b cnt=%0d mask=%h want all 0", {busy, done, pass}, err_cnt, fail_mask);
        end
        tick();
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++; $display("FAIL midrun_idle: got busy/done=%b want 00", {busy, done});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL midrun_rerun_e15: got done=%b want 0", done);
        end
        tick();
        total++;
        if ({busy, done, pass, err_cnt, fail_mask} !== {3'b011, 17'h0}) begin
            bad++; $display("FAIL midrun_rerun: got flags=%b cnt=%0d mask=%h want 011/0/000", {busy, done, pass}, err_cnt, fail_mask);
        end
    endtask

    task automatic test_restart_held();
        start = 1'b1; force_err = 1'b1;
        tick();
        start = 1'b0; force_err = 1'b0;
        for (int k = 1; k <= 16; k++) tick();
        total++;
        if ({done, err_cnt, fail_mask} !== {1'b1, 8'd16, 9'h004}) begin
            bad++; $display("FAIL held_run1: got done=%b cnt=%0d mask=%h want 1/16/004", done, err_cnt, fail_mask);
        end
        start = 1'b1;
        tick();
        total++;
        if ({busy, done, err_cnt, fail_mask} !== {2'b10, 17'h0}) begin
            bad++; $display("FAIL held_accept: got busy/done=%b cnt=%0d mask=%h want 10/0/000", {busy, done}, err_cnt, fail_mask);
        end
        for (int k = 1; k <= 16; k++) tick();
        total++;
        if ({busy, done, pass, err_cnt} !== {3'b011, 8'd0}) begin
            bad++; $display("FAIL held_run2: got flags=%b cnt=%0d want 011/0", {busy, done, pass}, err_cnt);
        end
        tick();
        start = 1'b0;
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++; $display("FAIL held_rerun: got busy/done=%b want 10", {busy, done});
        end
        for (int k = 1; k <= 16; k++) tick();
        total++;
        if ({busy, done, pass} !== 3'b011) begin
            bad++; $display("FAIL held_run3: got %b want 011", {busy, done, pass});
        end
    endtask

    task automatic test_stuck_or2();
        force dut.w_y_or2 = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 16; k++) tick();
        total++;
        if ({busy, done, pass} !== 3'b010) begin
            bad++; $display("FAIL or2_flags: got %b want 010", {busy, done, pass});
        end
        total++;
        if (err_cnt !== 8'd12 || fail_mask !== 9'h080) begin
            bad++; $display("FAIL or2_results: got cnt=%0d mask=%h want 12/080", err_cnt, fail_mask);
        end
        release dut.w_y_or2;
    endtask

    initial begin
        rst_b = 1'b0; start = 1'b0; force_err = 1'b0;
        test_reset();
        test_clean_run();
        test_force_err();
        test_start_ignored();
        test_reset_midrun();
        test_restart_held();
        test_stuck_or2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
